top_vector_sweep_checker: RTL and testbench

// - Drives the 4-bit input_data port of the combinational datapath block and consumes its 38-bit output_data.
// - On start, sweeps every input code 0..2^IN_W-1 and captures each response after LATENCY cycles.
// - Folds each captured response into a MISR and reports one OUT_W-bit signature.
// - Bench/BIST companion: the compressed signature is compared against a golden value.

---
 rtl/top_vector_sweep_checker.sv | 102 ++++++++++
 tb/tb_top_vector_sweep_checker.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/top_vector_sweep_checker.sv
// Sweeps every IN_W-bit stimulus code into a datapath under test and compresses
// the responses into an OUT_W-bit MISR signature for comparison against a golden value.
module top_vector_sweep_checker #(
  parameter int               IN_W    = 4,
  parameter int               OUT_W   = 38,
  parameter int               LATENCY = 0,
  parameter logic [OUT_W-1:0] POLY    = 38'h20_0000_0063,
  parameter logic [OUT_W-1:0] SEED    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic             sig_valid,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic [OUT_W-1:0] signature
);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t           state, next_state;
  logic [DW-1:0]    drain_cnt;
  logic             last_vec;
  logic             drain_last;
  logic             cap_valid;
  logic             fold_en;
  logic [OUT_W-1:0] misr_next;

  assign last_vec   = (dut_in == '1);
  assign drain_last = (drain_cnt == DW'(LATENCY - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation order between processes is irrelevant.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (start) next_state = DRIVE;
      DRIVE: if (!hold && last_vec) next_state = (LATENCY > 0) ? DRAIN : DONE;
      DRAIN: if (!hold && drain_last) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DRIVE) || (state == DRAIN);
    done = (state == DONE);
  end

  // Capture pipeline: a valid token travels alongside each presented vector so
  // the fold lines up with the DUT response LATENCY cycles later.
  if (LATENCY > 0) begin : g_pipe
    logic [LATENCY-1:0] pipe;
    always_ff @(posedge clk) begin
      if (rst || (state == IDLE && start)) pipe <= '0;
      else if (busy && !hold)              pipe <= (pipe << 1) | LATENCY'(state == DRIVE);
    end
    assign cap_valid = pipe[LATENCY-1];
  end else begin : g_comb
    assign cap_valid = (state == DRIVE);
  end

  assign fold_en   = cap_valid && busy && !hold;
  assign misr_next = {signature[OUT_W-2:0], 1'b0}
                   ^ (signature[OUT_W-1] ? POLY : '0)
                   ^ dut_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      dut_in    <= '0;
      signature <= '0;
      sig_valid <= 1'b0;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          dut_in    <= '0;
          signature <= SEED;
          sig_valid <= 1'b0;
          drain_cnt <= '0;
        end
        DRIVE: if (!hold && !last_vec) dut_in <= dut_in + 1'b1;
        DRAIN: if (!hold) drain_cnt <= drain_cnt + 1'b1;
        default: ;
      endcase
      if (fold_en) signature <= misr_next;
      if (next_state == DONE && state != DONE) sig_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_top_vector_sweep_checker.sv
// Self-checking bench: three checker instances (combinational DUT with SEED=1,
// 2-stage pipelined DUT, combinational DUT with SEED=0) against a software MISR.
module tb_top_vector_sweep_checker;

  localparam int               IN_W  = 4;
  localparam int               OUT_W = 38;
  localparam int               NV    = 1 << IN_W;
  localparam logic [OUT_W-1:0] POLY  = 38'h20_0000_0063;

  logic clk = 1'b0;
  logic rst, start, hold, zero_mode;
  always #5 clk = ~clk;

  logic             busy0, done0, sv0, busy1, done1, sv1, busy2, done2, sv2;
  logic [IN_W-1:0]  din0, din1, din2;
  logic [OUT_W-1:0] dout0, dout1, dout2, sig0, sig1, sig2;
  logic [OUT_W-1:0] lut0 [NV];
  logic [OUT_W-1:0] lut1 [NV];
  logic [OUT_W-1:0] stage_a, stage_b;

  int n_cmp = 0;
  int n_bad = 0;

  assign dout0 = zero_mode ? '0 : lut0[din0];
  assign dout2 = zero_mode ? '0 : lut0[din2];

  // Pipelined datapath shares the stall, as a real BIST-wrapped pipeline would.
  always @(posedge clk) begin
    if (rst) begin
      stage_a <= '0;
      stage_b <= '0;
    end else if (!hold) begin
      stage_a <= lut1[din1];
      stage_b <= stage_a;
    end
  end
  assign dout1 = stage_b;

  top_vector_sweep_checker #(.LATENCY(0), .SEED(38'h1)) u0 (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy0), .done(done0),
    .sig_valid(sv0), .dut_in(din0), .dut_out(dout0), .signature(sig0));
  top_vector_sweep_checker #(.LATENCY(2), .SEED(38'h0)) u1 (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy1), .done(done1),
    .sig_valid(sv1), .dut_in(din1), .dut_out(dout1), .signature(sig1));
  top_vector_sweep_checker #(.LATENCY(0), .SEED(38'h0)) u2 (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy2), .done(done2),
    .sig_valid(sv2), .dut_in(din2), .dut_out(dout2), .signature(sig2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Signature as a polynomial-division remainder accumulated over the response list.
  function automatic logic [OUT_W-1:0] model_sig(input logic [OUT_W-1:0] seed, input int sel);
    logic [OUT_W:0] acc;
    logic [OUT_W-1:0] r;
    acc = {1'b0, seed};
    for (int i = 0; i < NV; i++) begin
      if (sel == 1)      r = lut1[i];
      else if (zero_mode) r = '0;
      else               r = lut0[i];
      acc = acc * 2;
      if (acc[OUT_W]) acc = acc ^ {1'b1, POLY};
      acc = acc ^ {1'b0, r};
    end
    return acc[OUT_W-1:0];
  endfunction

  task automatic randomize_luts();
    zero_mode = 1'b0;
    for (int i = 0; i < NV; i++) begin
      lut0[i] = OUT_W'({$urandom(), $urandom()});
      lut1[i] = OUT_W'({$urandom(), $urandom()});
    end
  endtask

  // Runs a 40-cycle window; cycle 0 is the start-accept cycle.
  task automatic run_sweep(input int hold_at, input int hold_len, input int restart_at,
                           input int rst_at, output int d0, output int d1, output int d2);
    int  exp_in;
    logic held;
    exp_in = 0;
    d0 = -1; d1 = -1; d2 = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      held = (c >= hold_at) && (c < hold_at + hold_len);
      check("busy_done_excl", {busy0 & done0, busy1 & done1, busy2 & done2}, 0);
      if (c >= 1 && busy0) begin
        check("dut_in_step", din0, exp_in);
        check("sig_valid_low_busy", {sv0, sv1, sv2}, 0);
        if (!held && exp_in < NV - 1) exp_in++;
      end
      if (done0 && d0 < 0) d0 = c;
      if (done1 && d1 < 0) d1 = c;
      if (done2 && d2 < 0) d2 = c;
      if (rst_at >= 0 && c == rst_at + 1) begin
        check("rst_outs_u0", {busy0, done0, sv0, din0, sig0}, 0);
        check("rst_outs_u1", {busy1, done1, sv1, din1, sig1}, 0);
        check("rst_outs_u2", {busy2, done2, sv2, din2, sig2}, 0);
      end
      rst   = (c == rst_at);
      start = (c == 0) || (c == restart_at);
      hold  = held;
    end
    rst = 1'b0; start = 1'b0; hold = 1'b0;
  endtask

  task automatic check_result(input string tag, input int d0, input int d1, input int d2,
                              input int e0, input int e1);
    check({tag, "_done_u0"}, d0, e0);
    check({tag, "_done_u1"}, d1, e1);
    check({tag, "_done_u2"}, d2, e0);
    check({tag, "_sig_u0"}, sig0, model_sig(38'h1, 0));
    check({tag, "_sig_u1"}, sig1, model_sig(38'h0, 1));
    check({tag, "_sig_u2"}, sig2, model_sig(38'h0, 0));
    check({tag, "_sig_valid"}, {sv0, sv1, sv2}, 3'b111);
  endtask

  initial begin
    int d0, d1, d2, ha, hl;
    logic [OUT_W-1:0] held_sig;
    rst = 1'b1; start = 1'b0; hold = 1'b0; zero_mode = 1'b1;
    for (int i = 0; i < NV; i++) begin
      lut0[i] = OUT_W'({$urandom(), $urandom()});
      lut1[i] = OUT_W'(i);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_u0", {busy0, done0, sv0, din0, sig0}, 0);
    check("reset_u1", {busy1, done1, sv1, din1, sig1}, 0);
    check("reset_u2", {busy2, done2, sv2, din2, sig2}, 0);
    rst = 1'b0;

    // Tied-zero responses: SEED=1 just shifts up 16 places; SEED=0 stays 0.
    run_sweep(-100, 0, -1, -1, d0, d1, d2);
    check_result("zero", d0, d1, d2, 17, 19);
    check("zero_sig_const_u0", sig0, 38'h00_0001_0000);
    check("zero_sig_const_u2", sig2, 38'h0);
    held_sig = sig0;
    repeat (5) @(negedge clk);
    check("sig_valid_persist", {sv0, sv1, sv2}, 3'b111);
    check("sig_stable", sig0, held_sig);

    randomize_luts();
    run_sweep(5, 3, -1, -1, d0, d1, d2);
    check_result("hold3", d0, d1, d2, 20, 22);

    run_sweep(-100, 0, 5, -1, d0, d1, d2);
    check_result("restart", d0, d1, d2, 17, 19);

    run_sweep(0, 1, -1, -1, d0, d1, d2);
    check_result("start_hold_idle", d0, d1, d2, 17, 19);

    run_sweep(-100, 0, -1, 8, d0, d1, d2);
    check("rst_no_done", {d0 == -1, d1 == -1, d2 == -1}, 3'b111);

    run_sweep(-100, 0, -1, -1, d0, d1, d2);
    check_result("after_rst", d0, d1, d2, 17, 19);

    for (int k = 0; k < 3; k++) begin
      randomize_luts();
      ha = $urandom_range(2, 12);
      hl = $urandom_range(1, 4);
      run_sweep(ha, hl, -1, -1, d0, d1, d2);
      check_result("rand_hold", d0, d1, d2, 17 + hl, 19 + hl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
